// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parameterised pipeline register: DEPTH stages, each holding a valid bit and
// a WIDTH-bit payload. Supports stall (hold everything) and flush (squash all
// valid bits). Flush takes priority over stall. Payload leaving the last stage
// is gated by its valid bit so bubbles never expose stale data.
//
// Parameters
//   WIDTH  payload width per stage (>= 1)
//   DEPTH  number of register stages between input and output (>= 1)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high; clears all valid and data registers
//   in_valid    payload on in_data is a real instruction (0 = bubble)
//   in_data     payload from the upstream stage
//   stall       hold every stage unchanged this cycle
//   flush       invalidate every stage this cycle (wins over stall)
//   out_valid   valid bit of the last stage
//   out_data    last-stage payload, zero whenever out_valid is 0
//   occupancy   number of stages currently holding valid entries (0..DEPTH)
//   bubble_cnt  16-bit saturating count of edges with stall=0 and out_valid=0
//               (only present when PIPE_BUBBLE_CNT_EN is defined)
//
// Build option
//   PIPE_BUBBLE_CNT_EN  define to add the bubble counter and its port.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [15:0]                bubble_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic             shift_en;

  assign shift_en = !stall && !flush;

  // Stage valid bits: flush squashes regardless of stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // Stage payloads: held on flush since squashed entries are never exposed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_p[k] <= '0;
      end
    end else if (shift_en) begin
      data_p[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        data_p[k] <= data_p[k-1];
      end
    end
  end

  // Output of last stage
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1] & {WIDTH{out_valid}};

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(vld_p[k]);
    end
  end

`ifdef PIPE_BUBBLE_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!stall && !out_valid) begin
      bubble_cnt <= sat_inc16(bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic             d1_out_valid;
  logic [WIDTH-1:0] d1_out_data;
  logic [0:0]       d1_occupancy;
`ifdef PIPE_BUBBLE_CNT_EN
  logic [15:0]      bubble_cnt;
  logic [15:0]      d1_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               stg;
  } ent_t;

  // Scoreboard: in-flight valid entries with their stage index.
  ent_t        q[$];
  logic [15:0] m_bcnt = '0;

  pipe_stage_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  pipe_stage_reg #(.WIDTH(WIDTH), .DEPTH(1)) dut_d1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (d1_out_valid),
    .out_data  (d1_out_data),
    .occupancy (d1_occupancy)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt(d1_bubble_cnt)
`endif
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic m_vld();
    return (q.size() > 0) && (q[0].stg == DEPTH-1);
  endfunction

  function automatic logic [WIDTH-1:0] m_dat();
    return m_vld() ? q[0].d : '0;
  endfunction

  function automatic int m_occ();
    return q.size();
  endfunction

  // Drive one cycle at posedge+1, update the scoreboard at the edge, return at next posedge+1.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic st, input logic fl);
    logic ov;
    ent_t e;
    ov = m_vld();
    in_valid = v; in_data = d; stall = st; flush = fl;
    @(posedge clock);
    if (!st && !ov && m_bcnt != 16'hFFFF) m_bcnt++;
    if (fl) begin
      q.delete();
    end else if (!st) begin
      if (ov) void'(q.pop_front());
      foreach (q[i]) q[i].stg++;
      if (v) begin
        e.d = d; e.stg = 0;
        q.push_back(e);
      end
    end
    #1;
    in_valid = 0; in_data = '0; stall = 0; flush = 0;
  endtask

  task automatic async_reset();
    #2 reset = 1;
    q.delete();
    m_bcnt = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_vld got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_async_data got %02h want 00", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_async_occ got %0d want 0", occupancy); end
    #2 reset = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
`ifdef PIPE_BUBBLE_CNT_EN
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bcnt got %0d want 0", bubble_cnt); end
`endif
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_vld got %0b want 0", out_valid); end
    reset = 0;
  endtask

  task automatic test_stream();
    logic [7:0] din  [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] dout [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, din[i], 1'b0, 1'b0);
      checks++; if (occupancy !== 2'(i+1)) begin errors++; $display("FAIL stream_occ%0d got %0d want %0d", i, occupancy, i+1); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== (i < 3)) begin errors++; $display("FAIL stream_vld%0d got %0b want %0b", i, out_valid, i < 3); end
      checks++; if (out_data !== dout[i]) begin errors++; $display("FAIL stream_data%0d got %02h want %02h", i, out_data, dout[i]); end
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 8'hEE, 1'b1, 1'b0);
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_occ%0d got %0d want 2", i, occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_vld%0d got %0b want 0", i, out_valid); end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_exit1 got %0b/%02h want 1/11", out_valid, out_data); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_exit2 got %0b/%02h want 1/22", out_valid, out_data); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0, 1'b0);
    checks++; if (out_data !== 8'hA1 || occupancy !== 2'd3) begin errors++; $display("FAIL flush_full got %02h/%0d want a1/3", out_data, occupancy); end
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_vld got %0b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL flush_data got %02h want 00", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rmid_pre_occ got %0d want 2", occupancy); end
    async_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rmid_post_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_bubble_cnt();
`ifdef PIPE_BUBBLE_CNT_EN
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (bubble_cnt !== 16'd5) begin errors++; $display("FAIL bcnt_idle got %0d want 5", bubble_cnt); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (bubble_cnt !== 16'd5) begin errors++; $display("FAIL bcnt_stall got %0d want 5", bubble_cnt); end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checks++; if (bubble_cnt !== 16'd5) begin errors++; $display("FAIL bcnt_flush got %0d want 5", bubble_cnt); end
`endif
  endtask

  task automatic test_depth1();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++; if (d1_out_valid !== 1'b1 || d1_out_data !== 8'h5A) begin errors++; $display("FAIL d1_capture got %0b/%02h want 1/5a", d1_out_valid, d1_out_data); end
    checks++; if (d1_occupancy !== 1'b1) begin errors++; $display("FAIL d1_occ got %0d want 1", d1_occupancy); end
    cycle(1'b1, 8'h33, 1'b1, 1'b0);
    checks++; if (d1_out_data !== 8'h5A) begin errors++; $display("FAIL d1_stall got %02h want 5a", d1_out_data); end
    cycle(1'b0, 8'h77, 1'b0, 1'b0);
    checks++; if (d1_out_valid !== 1'b0 || d1_out_data !== 8'h00) begin errors++; $display("FAIL d1_bubble got %0b/%02h want 0/00", d1_out_valid, d1_out_data); end
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    checks++; if (d1_out_valid !== 1'b0) begin errors++; $display("FAIL d1_flush got %0b want 0", d1_out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(1, 255)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
      checks++; if (out_valid !== m_vld()) begin errors++; $display("FAIL rnd_vld%0d got %0b want %0b", n, out_valid, m_vld()); end
      checks++; if (out_data !== m_dat()) begin errors++; $display("FAIL rnd_data%0d got %02h want %02h", n, out_data, m_dat()); end
      checks++; if (int'(occupancy) != m_occ()) begin errors++; $display("FAIL rnd_occ%0d got %0d want %0d", n, occupancy, m_occ()); end
`ifdef PIPE_BUBBLE_CNT_EN
      checks++; if (bubble_cnt !== m_bcnt) begin errors++; $display("FAIL rnd_bcnt%0d got %0d want %0d", n, bubble_cnt, m_bcnt); end
`endif
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; stall = 0; flush = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_reset_mid();
    test_bubble_cnt();
    test_back_to_back();
    test_depth1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
